// File: rtl/vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_mem_sequencer: lane-serial VLDW/VLDH/VSTB memory sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vec_mem_sequencer #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [4:0]               opcode,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [2:0]               vreg_sel,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [ELEM_W-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [ELEM_W-1:0]        mem_rdata,
  output logic [2:0]               vreg_idx,
  output logic [$clog2(LANES)-1:0] vreg_lane,
  input  logic [ELEM_W-1:0]        vreg_rdata,
  output logic                     vreg_we,
  output logic [ELEM_W-1:0]        vreg_wdata,
  output logic                     stall,
  output logic                     done,
  output logic                     err
);

  localparam int LW = $clog2(LANES);
  localparam logic [4:0] OP_VLDW = 5'b11010;
  localparam logic [4:0] OP_VLDH = 5'b11011;
  localparam logic [4:0] OP_VSTB = 5'b11101;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          shamt_q, shamt_d;
  logic                store_q, store_d;
  logic [2:0]          vreg_q, vreg_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic                err_q, err_d;
  logic                legal_op;
  logic                last_lane;

  always_comb begin
    legal_op  = (opcode == OP_VLDW) || (opcode == OP_VLDH) || (opcode == OP_VSTB);
    last_lane = (lane_q == LAST_LANE);
    state_d   = state_q;
    base_d    = base_q;
    shamt_d   = shamt_q;
    store_d   = store_q;
    vreg_d    = vreg_q;
    lane_d    = lane_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // flush outranks a simultaneous launch, including an illegal one
        if (start && !flush) begin
          if (legal_op) begin
            state_d = S_REQ;
            base_d  = base_addr;
            vreg_d  = vreg_sel;
            lane_d  = '0;
            store_d = (opcode == OP_VSTB);
            shamt_d = (opcode == OP_VLDW) ? 2'd2 : ((opcode == OP_VLDH) ? 2'd1 : 2'd0);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_gnt) begin
          if (!store_q) begin
            state_d = S_WAIT;
          end else if (last_lane) begin
            state_d = S_DONE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_rvalid) begin
          if (last_lane) begin
            state_d = S_DONE;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      shamt_q <= 2'd0;
      store_q <= 1'b0;
      vreg_q  <= 3'd0;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      shamt_q <= shamt_d;
      store_q <= store_d;
      vreg_q  <= vreg_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
    end
  end

  // Strides are powers of two, so the lane offset is a shift; the sum wraps at 2^ADDR_W.
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req && store_q;
  assign mem_addr   = base_q + (ADDR_W'(lane_q) << shamt_q);
  assign mem_wdata  = mem_we ? vreg_rdata : '0;
  assign vreg_idx   = vreg_q;
  assign vreg_lane  = lane_q;
  assign vreg_we    = (state_q == S_WAIT) && mem_rvalid && !flush;
  assign vreg_wdata = vreg_we ? mem_rdata : '0;
  assign stall      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_sequencer: randomized bench with memory and register-file models.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vec_mem_sequencer;

  localparam int LANES  = 8;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 32;
  localparam logic [4:0] C_VLDW = 5'b11010;
  localparam logic [4:0] C_VLDH = 5'b11011;
  localparam logic [4:0] C_VSTB = 5'b11101;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        opcode;
  logic [ADDR_W-1:0] base_addr;
  logic [2:0]        vreg_sel;
  logic              flush;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [ELEM_W-1:0] mem_rdata;
  logic [2:0]        vreg_idx;
  logic [2:0]        vreg_lane;
  logic [ELEM_W-1:0] vreg_rdata;
  logic              vreg_we;
  logic [ELEM_W-1:0] vreg_wdata;
  logic              stall, done, err;

  logic [ELEM_W-1:0] vregs [8][LANES];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign vreg_rdata = vregs[vreg_idx][vreg_lane];

  vec_mem_sequencer #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .base_addr(base_addr),
    .vreg_sel(vreg_sel), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .vreg_idx(vreg_idx),
    .vreg_lane(vreg_lane), .vreg_rdata(vreg_rdata), .vreg_we(vreg_we),
    .vreg_wdata(vreg_wdata), .stall(stall), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int stride_of(input logic [4:0] op);
    if (op == C_VLDW) return 4;
    if (op == C_VLDH) return 2;
    return 1;
  endfunction

  // mode 0: random memory wait states and stray start strobes; mode 1: zero-wait memory
  task automatic run_op(input logic [4:0] op, input logic [31:0] base, input logic [2:0] vsel,
                        input int mode, input int hold_lane, input int abort_lane,
                        output bit aborted);
    int i, cyc, wdly, hold;
    bit waiting, fin, is_st;
    logic [31:0] ea;
    is_st = (op == C_VSTB);
    i = 0; cyc = 0; wdly = 0; hold = 3; waiting = 0; fin = 0; aborted = 0;
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_req", mem_req, 0);
    check("idle_done", done, 0);
    start = 1; opcode = op; base_addr = base; vreg_sel = vsel;
    flush = 0; mem_gnt = 0; mem_rvalid = 0;
    while (!fin && !aborted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; flush = 0;
      if (mode == 0 && $urandom_range(0, 3) == 0) begin
        start = 1; opcode = 5'($urandom); base_addr = $urandom; vreg_sel = 3'($urandom);
      end
      check("busy_stall", stall, 1);
      check("busy_done", done, 0);
      check("busy_err", err, 0);
      check("vreg_idx", vreg_idx, vsel);
      if (!waiting) begin
        ea = base + 32'(i * stride_of(op));
        check("req", mem_req, 1);
        check("addr", mem_addr, ea);
        check("we", mem_we, is_st);
        check("lane", vreg_lane, i);
        if (is_st) check("wdata", mem_wdata, vregs[vsel][i]);
        if (i == hold_lane && hold > 0) begin
          hold--;
        end else if (mode == 1 || $urandom_range(0, 2) != 0) begin
          mem_gnt = 1;
          if (is_st) begin
            i++;
            fin = (i == LANES);
          end else begin
            waiting = 1;
            wdly = (mode == 1) ? 0 : $urandom_range(0, 2);
          end
        end
      end else begin
        check("req_wait", mem_req, 0);
        if (i == abort_lane) begin
          flush = 1;
          aborted = 1;
        end else if (wdly == 0) begin
          mem_rvalid = 1;
          mem_rdata = 8'($urandom);
          #1;
          check("vreg_we", vreg_we, 1);
          check("vreg_lane", vreg_lane, i);
          check("vreg_wdata", vreg_wdata, mem_rdata);
          i++;
          waiting = 0;
          fin = (i == LANES);
        end else begin
          wdly--;
        end
      end
      if (!mem_rvalid) begin
        #1;
        check("vreg_we_idle", vreg_we, 0);
      end
    end
    if (!aborted) begin
      check("finished", fin, 1);
      @(negedge clk);
      start = 0; mem_gnt = 0; mem_rvalid = 0; flush = 0;
      check("done", done, 1);
      check("done_stall", stall, 0);
      check("done_req", mem_req, 0);
    end
  endtask

  task automatic post_abort();
    @(negedge clk);
    flush = 0; mem_gnt = 0; start = 0;
    check("abort_req", mem_req, 0);
    check("abort_stall", stall, 0);
    check("abort_done", done, 0);
    mem_rvalid = 1; mem_rdata = 8'h5A;
    #1;
    check("abort_vreg_we", vreg_we, 0);
  endtask

  initial begin
    logic [4:0] ops [3];
    logic [4:0] op;
    logic [31:0] b;
    bit ab;
    ops[0] = C_VLDW; ops[1] = C_VLDH; ops[2] = C_VSTB;
    for (int r = 0; r < 8; r++)
      for (int l = 0; l < LANES; l++) vregs[r][l] = 8'($urandom);
    rst = 0; start = 0; opcode = '0; base_addr = '0; vreg_sel = '0; flush = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    #12;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1;

    run_op(C_VSTB, 32'h100, 3'd3, 1, -1, -1, ab);
    run_op(C_VLDW, 32'h200, 3'd5, 1, -1, -1, ab);
    run_op(C_VLDH, 32'hFFFF_FFFC, 3'd1, 0, 2, -1, ab);

    // illegal opcode, then legal and illegal starts masked by flush
    @(negedge clk);
    start = 1; opcode = 5'b00000;
    @(negedge clk);
    start = 0;
    check("ill_err", err, 1);
    check("ill_stall", stall, 0);
    check("ill_req", mem_req, 0);
    start = 1; opcode = C_VSTB; flush = 1;
    @(negedge clk);
    check("ill_err_clear", err, 0);
    opcode = 5'b00001;
    @(negedge clk);
    start = 0; flush = 0;
    check("flush_start_stall", stall, 0);
    check("flush_start_err", err, 0);
    @(negedge clk);
    check("flush_ill_err", err, 0);
    check("flush_ill_req", mem_req, 0);

    run_op(C_VLDW, 32'h400, 3'd2, 1, -1, 3, ab);
    check("aborted", ab, 1);
    post_abort();
    run_op(C_VSTB, 32'h500, 3'd4, 1, -1, -1, ab);

    // asynchronous reset in the middle of a load, between clock edges
    @(negedge clk);
    start = 1; opcode = C_VLDW; base_addr = 32'h300; vreg_sel = 3'd6; mem_rvalid = 0;
    @(negedge clk);
    start = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    check("pre_rst_stall", stall, 1);
    mem_rvalid = 1; mem_rdata = 8'h77;
    #2 rst = 0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_we", mem_we, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_wdata", mem_wdata, 0);
    check("arst_vidx", vreg_idx, 0);
    check("arst_vlane", vreg_lane, 0);
    check("arst_vwe", vreg_we, 0);
    check("arst_vwdata", vreg_wdata, 0);
    check("arst_stall", stall, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    mem_rvalid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("post_rst_stall", stall, 0);
    check("post_rst_req", mem_req, 0);

    for (int n = 0; n < 20; n++) begin
      op = ops[$urandom_range(0, 2)];
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      run_op(op, b, 3'($urandom), 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, LANES - 1) : -1,
             ($urandom_range(0, 4) == 0) ? $urandom_range(0, LANES - 1) : -1, ab);
      if (ab) post_abort();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
